// File: rtl/service_2_countdown_pkg.sv
// service_2_countdown_pkg: shared states, BCD digit limits and mm:ss field positions
package service_2_countdown_pkg;
    typedef enum logic [2:0] {IDLE, LOADED, RUN, PAUSE, DONE} state_t;
    localparam int NUM_W = 16;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;
    localparam int SO_LSB = 0;
    localparam int ST_LSB = 4;
    localparam int MO_LSB = 8;
    localparam int MT_LSB = 12;
endpackage

// File: rtl/service_2_countdown_if.sv
// service_2_countdown_if: load/run controls in, remaining time and status out
interface service_2_countdown_if;
    logic finish1;
    logic [service_2_countdown_pkg::NUM_W-1:0] num_in;
    logic spdt2;
    logic push_c;
    logic [service_2_countdown_pkg::NUM_W-1:0] num_out;
    logic running;
    logic done;
    logic blink;
    modport master (output finish1, num_in, spdt2, push_c, input num_out, running, done, blink);
    modport slave (input finish1, num_in, spdt2, push_c, output num_out, running, done, blink);
endinterface

// File: rtl/service_2_countdown_bcd_mmss_dec.sv
// bcd_mmss_dec: one-second BCD mm:ss decrement that saturates at 00:00
module bcd_mmss_dec
    import service_2_countdown_pkg::*;
(
    input  logic [NUM_W-1:0] num,
    output logic [NUM_W-1:0] next_num,
    output logic             is_zero
);
    logic [3:0] so, st, mo, mt;
    logic [3:0] so_n, st_n, mo_n, mt_n;
    logic b0, b1, b2;
    assign so = num[SO_LSB +: 4];
    assign st = num[ST_LSB +: 4];
    assign mo = num[MO_LSB +: 4];
    assign mt = num[MT_LSB +: 4];
    // each bN marks a borrow rippling past the digit below
    assign b0 = so == 4'd0;
    assign b1 = b0 & (st == 4'd0);
    assign b2 = b1 & (mo == 4'd0);
    assign so_n = b0 ? DIGIT_MAX : so - 4'd1;
    assign st_n = b1 ? SEC_TENS_WRAP : b0 ? st - 4'd1 : st;
    assign mo_n = b2 ? DIGIT_MAX : b1 ? mo - 4'd1 : mo;
    assign mt_n = b2 ? mt - 4'd1 : mt;
    assign next_num = (num == '0) ? '0 : {mt_n, mo_n, st_n, so_n};
    assign is_zero = next_num == '0;
endmodule

// File: rtl/service_2_countdown.sv
// service_2_countdown: loads a BCD mm:ss value on finish1 rise, counts down once
// per TICK_DIV run cycles and latches an alarm with a blinking indicator at 00:00
module service_2_countdown
    import service_2_countdown_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input logic clk,
    input logic reset,
    service_2_countdown_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    state_t state_q, state_d;
    logic [NUM_W-1:0] cnt_q, cnt_d, dec_num;
    logic [PW-1:0] pre_q, pre_d;
    logic dec_zero, finish1_q, blink_q, blink_d, running_q, done_q, tick, load;
    bcd_mmss_dec u_dec (
        .num(cnt_q),
        .next_num(dec_num),
        .is_zero(dec_zero)
    );
    assign tick = pre_q == PRE_LAST;
    assign load = bus.finish1 & ~finish1_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        pre_d = pre_q;
        blink_d = blink_q;
        if (bus.push_c) begin
            state_d = IDLE;
            cnt_d = '0;
            pre_d = '0;
            blink_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    cnt_d = bus.num_in;
                    pre_d = '0;
                    state_d = (bus.num_in == '0) ? DONE : LOADED;
                end
                LOADED: state_d = bus.spdt2 ? RUN : LOADED;
                RUN: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    cnt_d = tick ? dec_num : cnt_q;
                    state_d = (tick && dec_zero) ? DONE : bus.spdt2 ? RUN : PAUSE;
                end
                PAUSE: state_d = bus.spdt2 ? RUN : PAUSE;
                DONE: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    cnt_d = '0;
                    blink_d = tick ? ~blink_q : blink_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pre_q <= '0;
            finish1_q <= 1'b0;
            blink_q <= 1'b0;
            running_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            finish1_q <= bus.finish1;
            blink_q <= blink_d;
            running_q <= state_d == RUN;
            done_q <= state_d == DONE;
        end
    end
    assign bus.num_out = cnt_q;
    assign bus.running = running_q;
    assign bus.done = done_q;
    assign bus.blink = blink_q;
endmodule

// File: tb/tb_service_2_countdown.sv
// tb_service_2_countdown: directed checks of load, BCD borrow, pause, alarm, clear and reset
module tb_service_2_countdown;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    service_2_countdown_if bus ();
    service_2_countdown #(.TICK_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        bus.push_c = 1'b1;
        step(1);
        bus.push_c = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        bus.num_in = v;
        bus.finish1 = 1'b1;
        step(1);
        bus.finish1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.finish1 = 1'b0;
        bus.num_in = 16'h0;
        bus.spdt2 = 1'b0;
        bus.push_c = 1'b0;
        step(2);
        chk("rst_num", bus.num_out, 16'h0);
        chk("rst_flags", {bus.running, bus.done, bus.blink}, 3'b000);
        reset = 1'b0;
        step(2);

        load(16'h0012);
        chk("load_0012", bus.num_out, 16'h0012);
        chk("loaded_not_running", bus.running, 1'b0);
        bus.spdt2 = 1'b1;
        step(1);
        chk("run_flag", bus.running, 1'b1);
        step(3);
        chk("pre_tick_0012", bus.num_out, 16'h0012);
        step(1);
        chk("tick1_0011", bus.num_out, 16'h0011);
        step(4);
        chk("tick2_0010", bus.num_out, 16'h0010);
        clear();
        chk("clear_num", bus.num_out, 16'h0);
        chk("clear_running", bus.running, 1'b0);

        load(16'h1000);
        step(5);
        chk("borrow_1000", bus.num_out, 16'h0959);
        clear();
        load(16'h0100);
        step(5);
        chk("borrow_0100", bus.num_out, 16'h0059);
        clear();
        load(16'h0099);
        step(5);
        chk("sec_tens_9", bus.num_out, 16'h0098);
        clear();

        bus.spdt2 = 1'b0;
        load(16'h0005);
        bus.spdt2 = 1'b1;
        step(2);
        bus.spdt2 = 1'b0;
        step(10);
        chk("pause_running", bus.running, 1'b0);
        chk("pause_hold", bus.num_out, 16'h0005);
        bus.spdt2 = 1'b1;
        step(2);
        chk("resume_pre", bus.num_out, 16'h0005);
        step(1);
        chk("resume_tick", bus.num_out, 16'h0004);
        clear();

        load(16'h0002);
        step(5);
        chk("done_cnt1", bus.num_out, 16'h0001);
        step(3);
        chk("done_not_yet", {bus.num_out, bus.done}, {16'h0001, 1'b0});
        step(1);
        chk("done_edge", {bus.num_out, bus.done, bus.running}, {16'h0000, 1'b1, 1'b0});
        chk("blink_start", bus.blink, 1'b0);
        step(3);
        chk("blink_before", bus.blink, 1'b0);
        step(1);
        chk("blink_on", bus.blink, 1'b1);
        step(4);
        chk("blink_off", bus.blink, 1'b0);
        clear();
        chk("done_clear", {bus.num_out, bus.done, bus.blink}, {16'h0000, 1'b0, 1'b0});

        bus.spdt2 = 1'b0;
        load(16'h0000);
        chk("zero_load_done", bus.done, 1'b1);
        clear();

        bus.spdt2 = 1'b1;
        load(16'h0003);
        step(4);
        bus.push_c = 1'b1;
        step(1);
        bus.push_c = 1'b0;
        chk("push_vs_tick", {bus.num_out, bus.running, bus.done}, {16'h0000, 1'b0, 1'b0});
        step(5);
        chk("idle_stays", bus.num_out, 16'h0);

        bus.spdt2 = 1'b0;
        bus.num_in = 16'h0007;
        bus.finish1 = 1'b1;
        step(1);
        chk("held_load", bus.num_out, 16'h0007);
        clear();
        step(3);
        chk("held_no_reload", bus.num_out, 16'h0);
        bus.finish1 = 1'b0;
        step(1);
        load(16'h0042);
        chk("reedge_load", bus.num_out, 16'h0042);
        step(1);
        load(16'h0055);
        chk("ignore_edge", bus.num_out, 16'h0042);

        bus.spdt2 = 1'b1;
        step(3);
        chk("pre_reset_run", bus.running, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_num", bus.num_out, 16'h0);
        chk("async_flags", {bus.running, bus.done, bus.blink}, 3'b000);
        step(1);
        reset = 1'b0;
        step(6);
        chk("post_reset_idle", {bus.num_out, bus.running}, {16'h0000, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
